adc_sgm58600_emu: RTL
=====================

Name: adc_sgm58600_emu

Overview:
Synthesizable SPI-slave emulator of the SGM58600/ADS1255 ADC. It is the device side of the existing ADC controller and is used for FPGA loopback and board-less bring-up. It runs on the same adc_clk the controller drives to the ADC, pacing conversions with DRDY. It decodes WREG/RDATAC/SDATAC commands, holds the register file, and shifts caller-supplied 24-bit samples out on DOUT.

Parameters:
CONV_PERIOD, 256, adc_clk cycles per conversion (30 kSPS at 7.68 MHz); legal range 64..65535
DRDY_HIGH_CLKS, 4, cycles DRDY is forced high before each conversion update
STATUS_RST, 8'h01, STATUS register reset value
MUX_RST, 8'h01, MUX register reset value
ADCON_RST, 8'h20, ADCON register reset value
DRATE_RST, 8'hF0, DRATE register reset value

Ports:
adc_clk  in  1  master clock; all logic on its rising edge
rstn  in  1  synchronous, active-low reset
adc_cs_n  in  1  chip select, active low
adc_sclk  in  1  serial clock from controller; min high/low 2 adc_clk
adc_din  in  1  serial command/data from controller
adc_sync_n  in  1  low = hold conversions
adc_dout  out  1  serial data to controller
adc_drdy_n  out  1  data ready, active low
sample_data  in  24  next conversion result, two's complement
conv_strobe  out  1  1-cycle pulse when sample_data is latched
reg_status, reg_mux, reg_adcon, reg_drate  out  8 each  current register contents
rdatac_mode  out  1  continuous-read mode active

Behaviour:
- Reset values: adc_dout=0, adc_drdy_n=1, conv_strobe=0, rdatac_mode=0, registers = *_RST, conversion counter=0, parser in CMD.
- SCLK handling: adc_sclk is registered into two stages. A rising edge is stage1 && !stage2; a falling edge is the converse. Detection latency is 1 cycle. All SPI logic ignores edges while adc_cs_n=1 and resets its bit counter when CS is high.
- DIN sampling: on each detected SCLK rising edge, shift adc_din MSB-first into an 8-bit byte register. A byte completes on the 8th rising edge.
- DOUT drive: on each detected SCLK rising edge while a read is active, present the next data bit. It is stable well before the controller samples 1 cycle later. The MSB is driven when DRDY falls.
- Conversion counter:
  - Counts 0..CONV_PERIOD-1 and wraps.
  - At count CONV_PERIOD-DRDY_HIGH_CLKS: force adc_drdy_n=1.
  - At wrap: latch sample_data into the 24-bit output shift register, pulse conv_strobe, drive adc_drdy_n=0.
  - adc_sync_n=0 clears the counter and holds adc_drdy_n=1.
- Parser FSM (one-hot):
  - CMD: on byte complete, decode it.
    - 0101_rrrr (WREG): save start address r, go to WCNT.
    - 0x03 (RDATAC): set rdatac_mode, go to RDC.
    - 0x0F (SDATAC): stay in CMD.
    - Any other byte is ignored.
  - WCNT: next byte gives low nibble n; remaining = n+1; go to WDATA.
  - WDATA: each completed byte is written to register addr, then addr+1. Addresses 4..15 are discarded. Return to CMD when remaining reaches 0.
  - RDC (rdatac_mode=1): while adc_drdy_n=0, SCLK rising edges shift out data. After the 24th rising edge, drive adc_drdy_n=1 on the following falling edge and hold it high until the next wrap.
    - Any bytes shifted in on DIN during RDC are decoded; only 0x0F (SDATAC) returns to CMD and clears rdatac_mode.
    - If 24 bits are not read before DRDY is forced high, the shift count resets at the next wrap with new data.
- Outside RDC, DRDY follows the conversion counter only. DOUT holds 0.
- rstn low mid-frame: all state returns to reset values on the next edge, including a partial byte or a partial WREG.
- Simultaneous conversion wrap and SCLK edge in RDC: the wrap wins; the shift count restarts and the MSB is driven.

Decomposition:
- Package adc_sgm58600_pkg holds:
  - Command codes WREG=4'b0101, RDATAC=8'h03, SDATAC=8'h0F.
  - Register addresses STATUS=0, MUX=1, ADCON=2, DRATE=3.
  - One-hot FSM state constants.
- One sub-module: adc_spi_slave_shifter, containing the SCLK synchronizer, edge detect, the 8-bit RX byte assembly with bit counter, and the 24-bit TX shift register. The FSM, register file and conversion counter stay in the top.

Test Plan:
1. Reset, adc_sync_n=1 → adc_drdy_n=1. First falling edge at cycle CONV_PERIOD after reset release; high DRDY_HIGH_CLKS=4 cycles before each later fall; conv_strobe pulses coincide with the falls.
2. Connect the existing ADC controller (STATUS=04, MUX=10, ADCON=01, DRATE=F0) → reg_status=04, reg_mux=10, reg_adcon=01, reg_drate=F0, then rdatac_mode=1.
3. In RDC, sample_data=24'hA5C30F → the controller outputs adc_dout_24b=A5C30F with a valid pulse. Repeat with 24'h800000 and 24'h7FFFFF; each is received exactly.
4. WREG with start address 3, n=2 (3 bytes) → reg_drate updated; bytes for addresses 4 and 5 dropped; parser back in CMD and accepts a following RDATAC.
5. Send SDATAC during RDC → rdatac_mode=0; later conversions keep DRDY toggling with DOUT=0.
6. Assert rstn low mid-WREG after 12 bits → registers return to *_RST, parser in CMD; a fresh WREG then succeeds.

Source files
------------

// File: rtl/adc_sgm58600_pkg.sv
// adc_sgm58600_pkg: command codes, register addresses and parser states of the ADC emulator
package adc_sgm58600_pkg;
  localparam logic [3:0] CMD_WREG = 4'b0101;
  localparam logic [7:0] CMD_RDATAC = 8'h03;
  localparam logic [7:0] CMD_SDATAC = 8'h0F;
  localparam logic [1:0] ADDR_STATUS = 2'd0;
  localparam logic [1:0] ADDR_MUX = 2'd1;
  localparam logic [1:0] ADDR_ADCON = 2'd2;
  localparam logic [1:0] ADDR_DRATE = 2'd3;
  typedef enum logic [3:0] {
    ST_CMD   = 4'b0001,
    ST_WCNT  = 4'b0010,
    ST_WDATA = 4'b0100,
    ST_RDC   = 4'b1000
  } state_t;
endpackage

// File: rtl/adc_sgm58600_emu_if.sv
// adc_sgm58600_emu_if: SPI, SYNC and DRDY wires between the ADC controller and the emulated device
interface adc_sgm58600_emu_if;
  logic adc_cs_n, adc_sclk, adc_din, adc_sync_n, adc_dout, adc_drdy_n;
  modport master(output adc_cs_n, adc_sclk, adc_din, adc_sync_n, input adc_dout, adc_drdy_n);
  modport slave(input adc_cs_n, adc_sclk, adc_din, adc_sync_n, output adc_dout, adc_drdy_n);
endinterface

// File: rtl/adc_sgm58600_emu_shifter.sv
// adc_spi_slave_shifter: SCLK edge detect, RX byte assembly and 24-bit TX shift register
module adc_spi_slave_shifter (
  input  logic        adc_clk,
  input  logic        rstn,
  input  logic        cs_n,
  input  logic        sclk,
  input  logic        din,
  input  logic        load,
  input  logic        shift_en,
  input  logic [23:0] load_data,
  output logic        fall,
  output logic        byte_done,
  output logic        tx_done,
  output logic        dout,
  output logic [7:0]  rx_byte
);
  logic s1, s2, rise;
  logic [2:0] bit_cnt;
  logic [6:0] rx_sr;
  logic [23:0] tx_sr;
  logic [4:0] tx_cnt;
  assign rise = s1 & ~s2 & ~cs_n;
  assign fall = ~s1 & s2 & ~cs_n;
  assign tx_done = tx_cnt == 5'd24;
  assign dout = tx_sr[23];
  always_ff @(posedge adc_clk) begin
    if (!rstn) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      bit_cnt <= '0;
      rx_sr <= '0;
      rx_byte <= '0;
      byte_done <= 1'b0;
      tx_sr <= '0;
      tx_cnt <= '0;
    end else begin
      s1 <= sclk;
      s2 <= s1;
      byte_done <= rise && bit_cnt == 3'd7;
      if (cs_n) bit_cnt <= '0;
      else if (rise) begin
        rx_sr <= {rx_sr[5:0], din};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) rx_byte <= {rx_sr, din};
      end
      // a new conversion always restarts the word, even mid-read
      if (load) begin
        tx_sr <= load_data;
        tx_cnt <= '0;
      end else if (shift_en && rise && !tx_done) begin
        tx_sr <= {tx_sr[22:0], 1'b0};
        tx_cnt <= tx_cnt + 5'd1;
      end
    end
  end
endmodule

// File: rtl/adc_sgm58600_emu.sv
// adc_sgm58600_emu: SPI-slave emulator of the SGM58600/ADS1255 for loopback and board-less bring-up
module adc_sgm58600_emu
  import adc_sgm58600_pkg::*;
#(
  parameter int CONV_PERIOD = 256,
  parameter int DRDY_HIGH_CLKS = 4,
  parameter logic [7:0] STATUS_RST = 8'h01,
  parameter logic [7:0] MUX_RST = 8'h01,
  parameter logic [7:0] ADCON_RST = 8'h20,
  parameter logic [7:0] DRATE_RST = 8'hF0
) (
  input  logic                      adc_clk,
  input  logic                      rstn,
  adc_sgm58600_emu_if.slave         spi,
  input  logic [23:0]               sample_data,
  output logic                      conv_strobe,
  output logic [7:0]                reg_status,
  output logic [7:0]                reg_mux,
  output logic [7:0]                reg_adcon,
  output logic [7:0]                reg_drate,
  output logic                      rdatac_mode
);
  localparam logic [15:0] LAST = 16'(CONV_PERIOD - 1);
  localparam logic [15:0] HIGH_AT = 16'(CONV_PERIOD - DRDY_HIGH_CLKS);
  logic [15:0] cnt, cnt_nxt;
  logic wrap, drdy_n, fall, byte_done, tx_done, tx_dout;
  logic [7:0] rx_byte;
  logic [7:0] regs [4];
  logic [4:0] addr, remain;
  state_t state;
  assign cnt_nxt = cnt == LAST ? '0 : cnt + 16'd1;
  assign wrap = spi.adc_sync_n && cnt == LAST;
  assign rdatac_mode = state == ST_RDC;
  assign spi.adc_dout = rdatac_mode & tx_dout;
  assign spi.adc_drdy_n = drdy_n;
  assign reg_status = regs[ADDR_STATUS];
  assign reg_mux = regs[ADDR_MUX];
  assign reg_adcon = regs[ADDR_ADCON];
  assign reg_drate = regs[ADDR_DRATE];
  adc_spi_slave_shifter u_shifter (
    .adc_clk(adc_clk), .rstn(rstn), .cs_n(spi.adc_cs_n), .sclk(spi.adc_sclk), .din(spi.adc_din),
    .load(wrap), .shift_en(rdatac_mode && !drdy_n), .load_data(sample_data),
    .fall(fall), .byte_done(byte_done), .tx_done(tx_done), .dout(tx_dout), .rx_byte(rx_byte)
  );
  always_ff @(posedge adc_clk) begin
    if (!rstn) begin
      cnt <= '0;
      drdy_n <= 1'b1;
      conv_strobe <= 1'b0;
    end else begin
      conv_strobe <= wrap;
      cnt <= spi.adc_sync_n ? cnt_nxt : '0;
      // a finished read releases DRDY early; it stays high until the next conversion
      if (!spi.adc_sync_n) drdy_n <= 1'b1;
      else if (wrap) drdy_n <= 1'b0;
      else if (cnt_nxt == HIGH_AT || (rdatac_mode && tx_done && fall)) drdy_n <= 1'b1;
    end
  end
  always_ff @(posedge adc_clk) begin
    if (!rstn) begin
      state <= ST_CMD;
      addr <= '0;
      remain <= '0;
      regs[ADDR_STATUS] <= STATUS_RST;
      regs[ADDR_MUX] <= MUX_RST;
      regs[ADDR_ADCON] <= ADCON_RST;
      regs[ADDR_DRATE] <= DRATE_RST;
    end else if (byte_done) begin
      unique case (state)
        ST_CMD: begin
          if (rx_byte[7:4] == CMD_WREG) begin
            addr <= {1'b0, rx_byte[3:0]};
            state <= ST_WCNT;
          end else if (rx_byte == CMD_RDATAC) state <= ST_RDC;
        end
        ST_WCNT: begin
          remain <= {1'b0, rx_byte[3:0]} + 5'd1;
          state <= ST_WDATA;
        end
        ST_WDATA: begin
          if (addr < 5'd4) regs[addr[1:0]] <= rx_byte;
          addr <= addr + 5'd1;
          remain <= remain - 5'd1;
          if (remain == 5'd1) state <= ST_CMD;
        end
        ST_RDC: if (rx_byte == CMD_SDATAC) state <= ST_CMD;
        default: state <= ST_CMD;
      endcase
    end
  end
endmodule
